gs_addsub_stage: RTL
====================

// Module: gs_addsub_stage
// PURPOSE
//  Modular add/sub front half of the inverse-NTT Gentleman-Sande butterfly.
//  Takes (a,b) and produces sum=(a+b) mod q and diff=(a-b) mod q.
//  sum feeds divby2 directly; diff feeds the twiddle multiplier, then divby2.
//  Two-stage elastic pipeline with valid/ready backpressure and a tag carried alongside.
// PARAMETERS
//  LOGQ       13  modulus width in bits
//  Q_VALUE    0   fixed modulus; 0 = runtime modulus built from qH
//  WORD_SIZE  8   low WORD_SIZE bits of q are 00..01 (runtime-q mode only)
//  TAG_W      8   width of the pass-through tag (bank address / index)
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  qH         in   LOGQ-WORD_SIZE  upper modulus bits; q={qH,{WORD_SIZE-1{0}},1}
//  in_valid   in   1               a/b/in_tag valid
//  in_ready   out  1               stage can accept this cycle
//  a          in   LOGQ            operand, 0<=a<q
//  b          in   LOGQ            operand, 0<=b<q
//  in_tag     in   TAG_W           opaque tag
//  out_valid  out  1               sum/diff/out_tag valid
//  out_ready  in   1               consumer accepts this cycle
//  sum        out  LOGQ            (a+b) mod q
//  diff       out  LOGQ            (a-b) mod q
//  out_tag    out  TAG_W           tag of the same transaction
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=s2_valid=0; sum, diff,
//    out_tag and all data regs = 0. In-flight data is dropped; no partial output.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - en2 = !s2_valid | out_ready;  en1 = !s1_valid | en2;  in_ready = en1.
//    in_ready is combinational from out_ready (no skid buffer). Stalls are bubble-free.
//  - S1 on en1: s1_valid<=in_valid;
//    s_raw<=a+b (LOGQ+1 b); d_raw<={1'b0,a}-{1'b0,b} (LOGQ+1 b, MSB=borrow).
//  - S2 on en2: s2_valid<=s1_valid;
//    sum<=(s_raw>=q)?s_raw-q:s_raw;  diff<=d_raw[LOGQ]?d_raw+q:d_raw (truncated to LOGQ).
//  - Tag moves with its data in both stages.
//  - Data regs load only when the matching valid is set. Bubbles keep old values.
//  - Latency: exactly 2 cycles from accept to out_valid with no backpressure.
//    Throughput: 1 transaction per cycle.
//  - Full with out_ready=0: in_ready=0 and outputs hold stable, unchanged.
//  - Simultaneous out and in transfer when full: both occur in the same cycle, no loss.
//  - Boundaries: a+b==q gives sum=0. a==b gives diff=0. a=0,b=q-1 gives diff=1.
//  - qH must be stable while any stage is valid. Inputs >=q are out of contract.
// STRUCTURE
//  - Shared package ntt_pkg holds:
//    - function build_q(qH) giving {qH,0..0,1}, honouring Q_VALUE!=0;
//    - localparam ADDSUB_LAT=2, so schedulers can align divby2 and multiplier latency.
//  - One sub-module: mod_correct (combinational conditional +/-q on a LOGQ+1-bit value).
//    Instantiated twice in S2: SUB mode for sum, ADD mode for diff.
// TESTING (q=7681, LOGQ=13, WORD_SIZE=8, qH=0x1E)
//  1. a=5000,b=4000, out_ready=1 -> 2 cycles later sum=1319, diff=1000, tag intact.
//  2. a=7680,b=1 -> sum=0, diff=7679.
//     a=0,b=1 -> sum=1, diff=7680.
//     a=b=3000 -> diff=0.
//  3. 16 back-to-back random pairs, out_ready=1 -> 16 outputs on consecutive cycles.
//     In order, matching the golden model, with in_ready held at 1.
//  4. out_ready=0 for 5 cycles with stream active -> in_ready=0 after 2 accepts.
//     sum/diff/tag stable. On release, all data is drained with no loss or duplication.
//  5. Random in_valid/out_ready toggling for 1000 cycles -> scoreboard in/out sequences match.
//  6. Assert rst with 2 items in flight -> out_valid=0 and outputs=0 immediately.
//     The next input after release appears 2 cycles later with no stale data.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: modulus construction and stage latencies
// used by schedulers to align the butterfly halves.
package ntt_pkg;

  // Cycles from accept to out_valid for gs_addsub_stage.
  localparam int unsigned ADDSUB_LAT = 2;

  typedef enum logic {
    MC_ADD,
    MC_SUB
  } mc_mode_e;

  // q = {qh, 0..0, 1} with word_size low bits, unless a fixed modulus is given.
  function automatic logic [31:0] build_q(input logic [31:0] qh,
                                          input int unsigned word_size,
                                          input logic [31:0] q_value);
    if (q_value != '0) return q_value;
    return (qh << word_size) | 32'd1;
  endfunction

endpackage

// File: rtl/mod_correct.sv
// Conditional modular correction of a LOGQ+1-bit raw add/sub result.
// SUB mode folds [0,2q) into [0,q); ADD mode lifts a borrowed difference.
module mod_correct
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ = 13,
  parameter mc_mode_e    MODE = MC_SUB
) (
  input  logic [LOGQ:0]   x,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ-1:0] y
);

  generate
    if (MODE == MC_SUB) begin : g_sub
      always_comb begin
        y = x[LOGQ-1:0];
        if (x >= {1'b0, q}) y = LOGQ'(x - {1'b0, q});
      end
    end else begin : g_add
      // MSB is the borrow of {0,a}-{0,b}; adding q wraps back into range.
      always_comb begin
        y = x[LOGQ-1:0];
        if (x[LOGQ]) y = LOGQ'(x + {1'b0, q});
      end
    end
  endgenerate

endmodule

// File: rtl/gs_addsub_stage.sv
// Add/sub front half of the inverse-NTT Gentleman-Sande butterfly:
// two-stage elastic pipeline producing (a+b) mod q and (a-b) mod q.
module gs_addsub_stage
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ      = 13,
  parameter int unsigned Q_VALUE   = 0,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LOGQ-WORD_SIZE-1:0] qH,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LOGQ-1:0]           a,
  input  logic [LOGQ-1:0]           b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LOGQ-1:0]           sum,
  output logic [LOGQ-1:0]           diff,
  output logic [TAG_W-1:0]          out_tag
);

  logic [LOGQ-1:0]  q;
  logic             en1, en2;
  logic             s1_valid, s2_valid;
  logic [LOGQ:0]    s_raw, d_raw;
  logic [TAG_W-1:0] s1_tag;
  logic [LOGQ-1:0]  sum_c, diff_c;

  assign q = LOGQ'(build_q(32'(qH), WORD_SIZE, 32'(Q_VALUE)));

  // No skid buffer: a stage advances whenever its downstream slot frees up.
  assign en2       = !s2_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s_raw    <= '0;
      d_raw    <= '0;
      s1_tag   <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s_raw  <= {1'b0, a} + {1'b0, b};
        d_raw  <= {1'b0, a} - {1'b0, b};
        s1_tag <= in_tag;
      end
    end
  end

  mod_correct #(
    .LOGQ (LOGQ),
    .MODE (MC_SUB)
  ) u_sum_corr (
    .x (s_raw),
    .q (q),
    .y (sum_c)
  );

  mod_correct #(
    .LOGQ (LOGQ),
    .MODE (MC_ADD)
  ) u_diff_corr (
    .x (d_raw),
    .q (q),
    .y (diff_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      diff     <= '0;
      out_tag  <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum     <= sum_c;
        diff    <= diff_c;
        out_tag <= s1_tag;
      end
    end
  end

endmodule
